// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PIPE,
    ST_LAST,
    ST_ERR
  } master_state_e;

  // Byte increment for a legal HSIZE; illegal sizes never reach the bus.
  function automatic logic [31:0] size_bytes(input logic [2:0] size);
    case (size)
      HSIZE_BYTE: size_bytes = 32'd1;
      HSIZE_HALF: size_bytes = 32'd2;
      HSIZE_WORD: size_bytes = 32'd4;
      default:    size_bytes = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational burst address helper: next-beat address and command legality.
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int BOUNDARY_LOG2 = 10
) (
  input  logic [31:0] cur_addr,
  input  logic [2:0]  cur_size,
  output logic [31:0] next_addr,
  input  logic [31:0] chk_addr,
  input  logic [2:0]  chk_size,
  input  logic        chk_incr4,
  output logic        chk_legal
);

  logic [31:0] last_addr;
  logic [31:0] crossed;
  logic        size_ok;
  logic        aligned;
  logic        no_cross;

  always_comb begin
    next_addr = cur_addr + size_bytes(cur_size);

    size_ok = (chk_size <= HSIZE_WORD);
    case (chk_size)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = ~chk_addr[0];
      HSIZE_WORD: aligned = (chk_addr[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase

    // Any differing bit at or above the boundary bit means the burst crosses it.
    last_addr = chk_addr + (size_bytes(chk_size) * 32'd3);
    crossed   = (chk_addr ^ last_addr) >> BOUNDARY_LOG2;
    no_cross  = !chk_incr4 || (crossed == 32'd0);

    chk_legal = size_ok && aligned && no_cross;
  end

endmodule

// File: rtl/ahb_master.sv
// Single-channel AHB-Lite initiator: one SINGLE or INCR4 command at a time,
// pipelined address/data phases with wait-state and two-cycle ERROR handling.
module ahb_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL     = 4'b0011,
  parameter int         BOUNDARY_LOG2 = 10
) (
  input  logic        HMASTCLOCK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic        cmd_burst,
  input  logic [31:0] cmd_wdata,
  output logic        wdata_pop,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        done_err,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  master_state_e state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [1:0]    htrans_d;
  logic [31:0]   haddr_d, hwdata_d, rdata_d;
  logic          hwrite_d, rdata_valid_d, done_d, done_err_d;
  logic [2:0]    hsize_d, hburst_d;
  logic [31:0]   next_addr;
  logic          cmd_legal;

  assign cmd_ready = (state_q == ST_IDLE);
  assign HPROT     = HPROT_VAL;

  ahb_addr_gen #(
    .BOUNDARY_LOG2(BOUNDARY_LOG2)
  ) u_addr_gen (
    .cur_addr (HADDR),
    .cur_size (HSIZE),
    .next_addr(next_addr),
    .chk_addr (cmd_addr),
    .chk_size (cmd_size),
    .chk_incr4(cmd_burst),
    .chk_legal(cmd_legal)
  );

  always_ff @(posedge HMASTCLOCK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      beat_q      <= 2'd0;
      HTRANS      <= HTRANS_IDLE;
      HADDR       <= 32'd0;
      HWDATA      <= 32'd0;
      HWRITE      <= 1'b0;
      HSIZE       <= HSIZE_WORD;
      HBURST      <= HBURST_SINGLE;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      HTRANS      <= htrans_d;
      HADDR       <= haddr_d;
      HWDATA      <= hwdata_d;
      HWRITE      <= hwrite_d;
      HSIZE       <= hsize_d;
      HBURST      <= hburst_d;
      rdata       <= rdata_d;
      rdata_valid <= rdata_valid_d;
      done        <= done_d;
      done_err    <= done_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    htrans_d      = HTRANS;
    haddr_d       = HADDR;
    hwdata_d      = HWDATA;
    hwrite_d      = HWRITE;
    hsize_d       = HSIZE;
    hburst_d      = HBURST;
    rdata_d       = rdata;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    done_err_d    = 1'b0;
    wdata_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_legal) begin
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else begin
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            hburst_d = cmd_burst ? HBURST_INCR4 : HBURST_SINGLE;
            beat_d   = 2'd0;
            state_d  = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          wdata_pop = HWRITE;
          if (HWRITE) hwdata_d = cmd_wdata;
          if (HBURST == HBURST_INCR4) begin
            htrans_d = HTRANS_SEQ;
            haddr_d  = next_addr;
            beat_d   = 2'd1;
            state_d  = ST_PIPE;
          end else begin
            htrans_d = HTRANS_IDLE;
            state_d  = ST_LAST;
          end
        end
      end

      // Data phase of beat_q-1 overlaps the address phase of beat_q.
      ST_PIPE: begin
        if (HRESP) begin
          htrans_d = HTRANS_IDLE;
          if (HREADY) begin
            done_d     = 1'b1;
            done_err_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (HREADY) begin
          wdata_pop = HWRITE;
          if (HWRITE) begin
            hwdata_d = cmd_wdata;
          end else begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end
          if (beat_q == 2'd3) begin
            htrans_d = HTRANS_IDLE;
            state_d  = ST_LAST;
          end else begin
            htrans_d = HTRANS_SEQ;
            haddr_d  = next_addr;
            beat_d   = beat_q + 2'd1;
          end
        end
      end

      ST_LAST: begin
        if (HRESP) begin
          if (HREADY) begin
            done_d     = 1'b1;
            done_err_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (HREADY) begin
          if (!HWRITE) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_ERR: begin
        if (HREADY) begin
          done_d     = 1'b1;
          done_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        htrans_d = HTRANS_IDLE;
        state_d  = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ahb_master.md
Name: ahb_master

Overview:
- Single-channel AHB-Lite initiator that drives the bus toward the existing slave blocks.
- Accepts one command at a time from a local requester: address, direction, size, and SINGLE or INCR4 burst.
- Runs the pipelined address and data phases, honouring wait states and two-cycle ERROR responses.
- Returns read data and a completion or error pulse to the requester.
- Sits between the test/CPU-side request logic and the AHB decoder/mux that fans out to slave_N blocks.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on HPROT (data access, privileged).
- BOUNDARY_LOG2, 10, log2 of the address boundary a burst must not cross (1 KB).

Ports:
- HMASTCLOCK  in  1  bus clock; all state changes on its rising edge
- HRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  requester presents a command
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where valid && ready
- cmd_addr  in  32  start address
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  3  HSIZE encoding; only 0, 1, 2 legal
- cmd_burst  in  1  0 = SINGLE, 1 = INCR4
- cmd_wdata  in  32  write data for the current beat; must be valid whenever wdata_pop is high
- wdata_pop  out  1  combinational; requester advances to its next write word after this edge
- rdata  out  32  captured read data
- rdata_valid  out  1  one-cycle pulse per successful read beat
- done  out  1  one-cycle pulse at command completion
- done_err  out  1  qualifies done; 1 = bus ERROR or rejected command
- HADDR  out  32  AHB address
- HWRITE  out  1  AHB direction
- HSIZE  out  3  AHB size
- HBURST  out  3  AHB burst type (SINGLE = 0, INCR4 = 3)
- HPROT  out  4  AHB protection; always HPROT_VAL
- HTRANS  out  2  AHB transfer type
- HWDATA  out  32  AHB write data
- HREADY  in  1  bus ready, taken from the slave mux
- HRESP  in  1  0 = OKAY, 1 = ERROR
- HRDATA  in  32  AHB read data

Behaviour:
- Reset (async assert, sync release):
  - Registered outputs: HTRANS = IDLE, HADDR = 0, HWDATA = 0, HWRITE = 0, HSIZE = 3'b010, HBURST = 0, rdata = 0, rdata_valid = 0, done = 0, done_err = 0.
  - State returns to IDLE, so cmd_ready = 1 from the first cycle after reset.
  - A reset mid-command abandons it with no done pulse.
- States: IDLE, ADDR, PIPE, LAST, ERR.
- IDLE:
  - On accept, check legality: cmd_size > 2, or cmd_addr not size-aligned, or an INCR4 that crosses a 2^BOUNDARY_LOG2 boundary (start and last-beat address differ above bit BOUNDARY_LOG2-1).
  - Illegal command: no bus activity, done = done_err = 1 next cycle, stay in IDLE.
  - Legal command: latch it, drive HTRANS = NONSEQ, HADDR = cmd_addr, HBURST, HSIZE, HWRITE, and go to ADDR.
- Address phase completion:
  - An address phase completes on an edge with HREADY = 1.
  - The data phase for that beat starts on the same edge.
  - For a write, HWDATA <= cmd_wdata on that edge and wdata_pop is high in the cycle before it.
- ADDR (beat 0 in address phase):
  - On completion, if beats remain: HTRANS = SEQ, HADDR += 1 << size, go to PIPE.
  - Otherwise: HTRANS = IDLE, go to LAST.
- PIPE (data phase of beat i overlaps address phase of beat i+1):
  - On an HREADY edge with HRESP = 0, both phases advance.
  - Go to LAST after the 4th address phase completes.
- LAST (final data phase, no address outstanding):
  - On an HREADY edge: done pulses next cycle and the block returns to IDLE.
  - cmd_ready is high in the same cycle as done.
- Read capture: every data phase completing with HREADY = 1 and HRESP = 0 during a read loads rdata <= HRDATA and pulses rdata_valid the next cycle.
- Wait states (HREADY = 0): hold HADDR, HTRANS, HWDATA and all controls stable.
- ERROR response:
  - HRESP = 1 with HREADY = 0 during a data phase: next cycle drive HTRANS = IDLE, cancelling any pending SEQ, and go to ERR.
  - ERR waits for the edge with HREADY = 1, then pulses done = done_err = 1 and returns to IDLE.
  - No rdata_valid pulse for the errored beat; remaining beats are never issued.
- BUSY transfer type is never driven.
- Latency: a zero-wait SINGLE pulses done 3 cycles after the accept edge; each wait state adds one cycle.
- An INCR4 with zero wait states pulses done 6 cycles after the accept edge.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HBURST_SINGLE/INCR4
  - HSIZE_BYTE/HALF/WORD
  - the state encoding for this block
- One natural sub-module: ahb_addr_gen.
  - Performs next-address increment by size.
  - Computes the alignment and boundary legality check.
  - Combinational, reusable by later burst-capable masters.

Test Plan:
- SINGLE word write to 0x20000010, data 0xDEADBEEF, HREADY always 1 -> NONSEQ at cycle 1; HWDATA = 0xDEADBEEF in cycle 2; done = 1, done_err = 0 in cycle 3; one wdata_pop.
- SINGLE read from 0x20000000, slave inserts 2 wait states then returns 0x20000000 -> HADDR/HTRANS held during the waits; rdata = 0x20000000 with rdata_valid one pulse; done 5 cycles after accept.
- INCR4 word write from 0x20000100 -> HTRANS NONSEQ, SEQ, SEQ, SEQ with HADDR 0x100, 0x104, 0x108, 0x10C; 4 wdata_pop pulses; HTRANS IDLE after the 4th address; done with no error.
- INCR4 read with ERROR on beat 1 -> HTRANS = IDLE in the cycle after HRESP = 1 & HREADY = 0; only 1 rdata_valid pulse; done = done_err = 1; no further addresses issued.
- INCR4 word read at 0x200003F8, plus a word read at 0x20000002 -> both rejected: HTRANS stays IDLE, done = done_err = 1 one cycle after accept.
- HRESETn low during PIPE of an INCR4 write -> all outputs return to reset values immediately; no done pulse; cmd_ready = 1 after release.
